uart_tx_arbiter: RTL and testbench

Shares one UART_TX instance between NUM_REQ byte-stream requesters. Uses round-robin arbitration with frame locking: a requester keeps the transmitter until it sends a byte marked last. Each byte is handed to UART_TX as a single-cycle data-valid pulse. The block then waits for the transmitter's done pulse, applies an optional inter-byte gap, and runs a watchdog that recovers from a missing done pulse. It sits between the protocol sources (command/response engines) and UART_TX.

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte-stream
// requesters. Round-robin between frames, frame-locked within a frame.
// Each byte is issued as a one-cycle data-valid pulse. The arbiter then waits
// for the transmitter's done pulse, optionally idles for GAP_CLKS clocks, and
// aborts through a watchdog if the done pulse never arrives.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 217,
  parameter int TIMEOUT_CLKS = 2560,
  parameter int GAP_CLKS     = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Done,
  input  logic                 i_TX_Active,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  // The watchdog must never fire before a full 10-bit frame can complete, so
  // an undersized TIMEOUT_CLKS is raised to one clock past a frame time.
  localparam int FRAME_CLKS = 10 * CLKS_PER_BIT;
  localparam int TMO_LIMIT  = (TIMEOUT_CLKS > FRAME_CLKS) ? TIMEOUT_CLKS : FRAME_CLKS + 1;
  localparam int TMO_W      = $clog2(TMO_LIMIT);
  localparam int GAP_W      = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int IDX_W      = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_q;
  logic               lock_q;
  logic               last_q;
  logic [7:0]         byte_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [GAP_W-1:0]   gap_q;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               start;
  logic               tmo_hit;
  logic               gap_done;

  // Owner index plus one, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  // Candidate selection: the locked owner only, otherwise first DV from rr_q upward.
  always_comb begin
    int j;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    sel_valid = 1'b0;
    sel_idx   = '0;
    j         = 0;
    if (lock_q) begin
      if (i_Req_DV[owner_q]) begin
        sel_valid = 1'b1;
        sel_idx   = owner_q;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        j = (int'(rr_q) + i) % NUM_REQ;
        if (!sel_valid && i_Req_DV[j]) begin
          sel_valid = 1'b1;
          sel_idx   = IDX_W'(j);
        end
      end
    end
  end

  assign start    = (state_q == S_IDLE) && !i_TX_Active && sel_valid;
  assign tmo_hit  = (tmo_q == TMO_W'(TMO_LIMIT - 1));
  assign gap_done = (int'(gap_q) == GAP_CLKS - 1);

  // State register.
  always_ff @(posedge i_Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i_TX_Done)    state_d = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_GAP:       if (gap_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath: latch the selected byte, run the counters, update lock and RR pointer.
  always_ff @(posedge i_Clock) begin
    // NOTE: every control and data register is reset; there is no memory array to exempt.
    if (i_Reset) begin
      owner_q <= '0;
      rr_q    <= '0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      byte_q  <= 8'h00;
      grant_q <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            owner_q <= sel_idx;
            byte_q  <= i_Req_Byte[8*int'(sel_idx) +: 8];
            last_q  <= i_Req_Last[sel_idx];
            grant_q <= NUM_REQ'(1) << sel_idx;
          end
        end
        S_ISSUE: tmo_q <= '0;
        S_WAIT_DONE: begin
          tmo_q <= tmo_q + TMO_W'(1);
          gap_q <= '0;
          if (i_TX_Done) begin
            if (last_q) begin
              lock_q  <= 1'b0;
              rr_q    <= inc_wrap(owner_q);
              grant_q <= '0;
            end else begin
              lock_q  <= 1'b1;
            end
          end else if (tmo_hit) begin
            // Abandon the frame; the stuck byte is dropped, not retried.
            lock_q  <= 1'b0;
            rr_q    <= inc_wrap(owner_q);
            grant_q <= '0;
          end
        end
        S_GAP: gap_q <= gap_q + GAP_W'(1);
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    o_TX_DV   = (state_q == S_ISSUE);
    o_Req_Ack = (state_q == S_ISSUE) ? grant_q : '0;
    o_TX_Byte = byte_q;
    o_Grant   = grant_q;
    o_Busy    = (state_q != S_IDLE) || lock_q;
    o_Timeout = (state_q == S_WAIT_DONE) && !i_TX_Done && tmo_hit;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. The transmitter is modelled by driving
// r_TX_Done / r_TX_Active by hand. A second instance with GAP_CLKS=5 shares
// the stimulus and is only observed during the gap and reset steps.
module tb_uart_tx_arbiter;

  logic        r_Clock;
  logic        r_Reset;
  logic [3:0]  r_Req_DV;
  logic [31:0] r_Req_Byte;
  logic [3:0]  r_Req_Last;
  logic        r_TX_Done;
  logic        r_TX_Active;

  logic [3:0]  w_Req_Ack, w_Grant;
  logic        w_TX_DV, w_Busy, w_Timeout;
  logic [7:0]  w_TX_Byte;

  logic [3:0]  wg_Req_Ack, wg_Grant;
  logic        wg_TX_DV, wg_Busy, wg_Timeout;
  logic [7:0]  wg_TX_Byte;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arbiter dut (
    .i_Clock(r_Clock), .i_Reset(r_Reset),
    .i_Req_DV(r_Req_DV), .i_Req_Byte(r_Req_Byte), .i_Req_Last(r_Req_Last),
    .o_Req_Ack(w_Req_Ack), .o_TX_DV(w_TX_DV), .o_TX_Byte(w_TX_Byte),
    .i_TX_Done(r_TX_Done), .i_TX_Active(r_TX_Active),
    .o_Grant(w_Grant), .o_Busy(w_Busy), .o_Timeout(w_Timeout)
  );

  uart_tx_arbiter #(.GAP_CLKS(5)) dut_gap (
    .i_Clock(r_Clock), .i_Reset(r_Reset),
    .i_Req_DV(r_Req_DV), .i_Req_Byte(r_Req_Byte), .i_Req_Last(r_Req_Last),
    .o_Req_Ack(wg_Req_Ack), .o_TX_DV(wg_TX_DV), .o_TX_Byte(wg_TX_Byte),
    .i_TX_Done(r_TX_Done), .i_TX_Active(r_TX_Active),
    .o_Grant(wg_Grant), .o_Busy(wg_Busy), .o_Timeout(wg_Timeout)
  );

  initial r_Clock = 1'b0;
  always #5 r_Clock = ~r_Clock;

  // Hard stop in case a bounded loop is ever miscoded.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge r_Clock);
    #1;
  endtask

  // Wait (bounded) for o_TX_DV on the main instance and check the issued byte.
  task automatic expect_issue(input logic [7:0] exp_byte, input logic [3:0] exp_ack,
                              input int exp_lat, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!w_TX_DV && n < 50);
    check({tag, "_dv"},   {31'd0, w_TX_DV}, 32'd1);
    check({tag, "_lat"},  32'(n), 32'(exp_lat));
    check({tag, "_byte"}, {24'd0, w_TX_Byte}, {24'd0, exp_byte});
    check({tag, "_ack"},  {28'd0, w_Req_Ack}, {28'd0, exp_ack});
  endtask

  // ISSUE -> WAIT_DONE, then a single done pulse from the transmitter.
  task automatic finish_byte();
    tick();
    r_TX_Done = 1'b1;
    tick();
    r_TX_Done = 1'b0;
  endtask

  initial begin
    int n;
    r_Reset     = 1'b1;
    r_Req_DV    = '0;
    r_Req_Byte  = '0;
    r_Req_Last  = '0;
    r_TX_Done   = 1'b0;
    r_TX_Active = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst_dv",    {31'd0, w_TX_DV}, 32'd0);
    check("rst_ack",   {28'd0, w_Req_Ack}, 32'd0);
    check("rst_byte",  {24'd0, w_TX_Byte}, 32'd0);
    check("rst_grant", {28'd0, w_Grant}, 32'd0);
    check("rst_busy",  {31'd0, w_Busy}, 32'd0);
    check("rst_tmo",   {31'd0, w_Timeout}, 32'd0);
    r_Reset = 1'b0;

    // Single requester, held off while the transmitter is active.
    r_TX_Active       = 1'b1;
    r_Req_DV[0]       = 1'b1;
    r_Req_Byte[7:0]   = 8'h3F;
    r_Req_Last[0]     = 1'b1;
    repeat (3) tick();
    check("active_hold_dv",    {31'd0, w_TX_DV}, 32'd0);
    check("active_hold_grant", {28'd0, w_Grant}, 32'd0);
    r_TX_Active = 1'b0;
    expect_issue(8'h3F, 4'b0001, 1, "single");
    check("single_grant", {28'd0, w_Grant}, 32'h1);
    r_Req_DV[0] = 1'b0;
    finish_byte();
    check("single_grant_after", {28'd0, w_Grant}, 32'h0);
    check("single_busy_after",  {31'd0, w_Busy}, 32'd0);

    // Round robin from reset: A0..A3, then A2 before A0 once A0 was just served.
    r_Reset    = 1'b1;
    tick();
    r_Req_Byte = 32'hA3A2A1A0;
    r_Req_Last = 4'b1111;
    r_Req_DV   = 4'b1111;
    r_Reset    = 1'b0;
    expect_issue(8'hA0, 4'b0001, 1, "rr0"); r_Req_DV[0] = 1'b0; finish_byte();
    expect_issue(8'hA1, 4'b0010, 1, "rr1"); r_Req_DV[1] = 1'b0; finish_byte();
    expect_issue(8'hA2, 4'b0100, 1, "rr2"); r_Req_DV[2] = 1'b0; finish_byte();
    expect_issue(8'hA3, 4'b1000, 1, "rr3"); r_Req_DV[3] = 1'b0; finish_byte();
    r_Req_DV[0] = 1'b1;
    expect_issue(8'hA0, 4'b0001, 1, "rr0b"); r_Req_DV[0] = 1'b0; finish_byte();
    r_Req_DV = 4'b0101;
    expect_issue(8'hA2, 4'b0100, 1, "rr_wrap2"); r_Req_DV[2] = 1'b0; finish_byte();
    expect_issue(8'hA0, 4'b0001, 1, "rr_wrap0"); r_Req_DV[0] = 1'b0; finish_byte();

    // Frame lock: req1 sends 11,12,13 while req0 waits with 55.
    r_Req_Byte[7:0]  = 8'h55; r_Req_Last[0] = 1'b1; r_Req_DV[0] = 1'b1;
    r_Req_Byte[15:8] = 8'h11; r_Req_Last[1] = 1'b0; r_Req_DV[1] = 1'b1;
    expect_issue(8'h11, 4'b0010, 1, "lock_b1");
    r_Req_Byte[15:8] = 8'h12;
    finish_byte();
    check("lock_grant1", {28'd0, w_Grant}, 32'h2);
    check("lock_busy1",  {31'd0, w_Busy}, 32'd1);
    expect_issue(8'h12, 4'b0010, 1, "lock_b2");
    r_Req_Byte[15:8] = 8'h13; r_Req_Last[1] = 1'b1;
    finish_byte();
    check("lock_grant2", {28'd0, w_Grant}, 32'h2);
    expect_issue(8'h13, 4'b0010, 1, "lock_b3");
    r_Req_DV[1] = 1'b0;
    finish_byte();
    check("lock_grant_end", {28'd0, w_Grant}, 32'h0);
    expect_issue(8'h55, 4'b0001, 1, "lock_req0"); r_Req_DV[0] = 1'b0; finish_byte();

    // Locked owner drops DV mid-frame: other requesters are starved.
    r_Req_Byte[31:24] = 8'hE1; r_Req_Last[3] = 1'b0; r_Req_DV[3] = 1'b1;
    expect_issue(8'hE1, 4'b1000, 1, "starve_b1");
    r_Req_DV[3] = 1'b0;
    finish_byte();
    r_Req_DV[0] = 1'b1;
    repeat (4) tick();
    check("starve_dv",    {31'd0, w_TX_DV}, 32'd0);
    check("starve_grant", {28'd0, w_Grant}, 32'h8);
    check("starve_busy",  {31'd0, w_Busy}, 32'd1);
    r_Req_Byte[31:24] = 8'hE2; r_Req_Last[3] = 1'b1; r_Req_DV[3] = 1'b1;
    expect_issue(8'hE2, 4'b1000, 1, "starve_b2"); r_Req_DV[3] = 1'b0; finish_byte();
    expect_issue(8'h55, 4'b0001, 1, "starve_req0"); r_Req_DV[0] = 1'b0; finish_byte();

    // Watchdog: no done for byte 77; o_Timeout 2560 clocks after o_TX_DV, then 88.
    r_Req_Byte[23:16] = 8'h77; r_Req_Last[2] = 1'b1; r_Req_DV[2] = 1'b1;
    r_Req_Byte[31:24] = 8'h88; r_Req_Last[3] = 1'b1; r_Req_DV[3] = 1'b1;
    expect_issue(8'h77, 4'b0100, 1, "tmo_b");
    r_Req_DV[2] = 1'b0;
    n = 0;
    while (!w_Timeout && n < 3000) begin
      tick();
      n++;
    end
    check("tmo_latency", 32'(n), 32'd2560);
    check("tmo_grant_at", {28'd0, w_Grant}, 32'h4);
    tick();
    check("tmo_pulse_one", {31'd0, w_Timeout}, 32'd0);
    check("tmo_grant_clr", {28'd0, w_Grant}, 32'h0);
    expect_issue(8'h88, 4'b1000, 1, "tmo_next");
    r_Req_DV[3] = 1'b0;
    finish_byte();

    // Done arriving on the last watchdog count wins over the timeout.
    r_Req_Byte[15:8] = 8'h99; r_Req_Last[1] = 1'b1; r_Req_DV[1] = 1'b1;
    expect_issue(8'h99, 4'b0010, 1, "race_b");
    r_Req_DV[1] = 1'b0;
    repeat (2560) tick();
    check("race_armed", {31'd0, w_Timeout}, 32'd1);
    r_TX_Done = 1'b1;
    #1;
    check("race_done_wins", {31'd0, w_Timeout}, 32'd0);
    tick();
    r_TX_Done = 1'b0;
    check("race_grant", {28'd0, w_Grant}, 32'h0);
    check("race_busy",  {31'd0, w_Busy}, 32'd0);

    // Gap instance: 5 inserted gap clocks plus the arbitration clock after done.
    r_Reset = 1'b1;
    tick();
    r_Req_Byte[7:0] = 8'h5A; r_Req_Last[0] = 1'b0; r_Req_DV[0] = 1'b1;
    r_Reset = 1'b0;
    tick();
    check("gap_first_dv",   {31'd0, wg_TX_DV}, 32'd1);
    check("gap_first_byte", {24'd0, wg_TX_Byte}, 32'h5A);
    r_Req_Byte[7:0] = 8'h5B; r_Req_Last[0] = 1'b1;
    finish_byte();
    n = 1;
    while (!wg_TX_DV && n < 50) begin
      check("gap_busy", {31'd0, wg_Busy}, 32'd1);
      tick();
      n++;
    end
    check("gap_done_to_dv", 32'(n), 32'd7);
    check("gap_second_byte", {24'd0, wg_TX_Byte}, 32'h5B);
    r_Req_DV[0] = 1'b0;

    // Main instance is mid-byte on 5B; reset, then a stray done is ignored.
    tick();
    check("midrst_busy",  {31'd0, w_Busy}, 32'd1);
    check("midrst_grant", {28'd0, w_Grant}, 32'h1);
    r_Reset = 1'b1;
    tick();
    r_Reset = 1'b0;
    check("midrst_dv",    {31'd0, w_TX_DV}, 32'd0);
    check("midrst_byte",  {24'd0, w_TX_Byte}, 32'h0);
    check("midrst_grant0", {28'd0, w_Grant}, 32'h0);
    check("midrst_busy0", {31'd0, w_Busy}, 32'd0);
    check("midrst_gap_grant", {28'd0, wg_Grant}, 32'h0);
    r_TX_Done = 1'b1;
    tick();
    r_TX_Done = 1'b0;
    check("stray_dv",   {31'd0, w_TX_DV}, 32'd0);
    check("stray_ack",  {28'd0, w_Req_Ack}, 32'h0);
    check("stray_busy", {31'd0, w_Busy}, 32'd0);
    tick();
    check("stray_dv2",  {31'd0, w_TX_DV}, 32'd0);
    check("stray_gap_dv", {31'd0, wg_TX_DV}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
